// File: rtl/adc_serial_reader_if.sv
// Sample stream from the ADC front end into the effects pipeline.
// The reader drives it as master; the pipeline consumes it as slave.
interface adc_serial_reader_if;
  logic [11:0] sample_out;
  logic        sample_valid;
  logic        frame_err;

  modport master (output sample_out, output sample_valid, output frame_err);
  modport slave  (input  sample_out, input  sample_valid, input  frame_err);
endinterface

// File: rtl/adc_serial_reader.sv
// Periodic reader for a 12-bit serial ADC (16-SCLK frame, 4 leading zeros, MSB first).
// Converts each code to two's complement and strobes it into the pipeline.

module adc_serial_reader_param_chk #(
  parameter int CLK_DIV       = 2,
  parameter int SAMPLE_PERIOD = 1042
) ();
  if (CLK_DIV < 1) begin : g_bad_div
    $error("adc_serial_reader: CLK_DIV must be >= 1");
  end
  // A full frame plus the DONE and IDLE cycles must fit inside one period.
  if (SAMPLE_PERIOD < 33 * CLK_DIV + 2) begin : g_bad_period
    $error("adc_serial_reader: SAMPLE_PERIOD must be >= 33*CLK_DIV+2");
  end
endmodule

module adc_serial_reader #(
  parameter int CLK_DIV       = 2,
  parameter int SAMPLE_PERIOD = 1042,
  parameter bit OFFSET_BINARY = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic                       adc_miso,
  output logic                       adc_cs_n,
  output logic                       adc_sclk,
  adc_serial_reader_if.master        sample_if
);

  localparam int TMR_W = $clog2(SAMPLE_PERIOD);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [11:0] SIGN_FLIP = OFFSET_BINARY ? 12'h800 : 12'h000;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_SHIFT_LO = 3'd2,
    ST_SHIFT_HI = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  state_t             state_r;
  logic [TMR_W-1:0]   timer_r;
  logic [DIV_W-1:0]   div_r;
  logic [4:0]         bit_cnt_r;
  logic [15:0]        shreg_r;
  logic               start_s;
  logic               div_last_s;

  adc_serial_reader_param_chk #(
    .CLK_DIV       (CLK_DIV),
    .SAMPLE_PERIOD (SAMPLE_PERIOD)
  ) u_param_chk ();

  function automatic logic [11:0] to_twos(input logic [11:0] code);
    return code ^ SIGN_FLIP;
  endfunction

  assign start_s    = enable && (timer_r == '0) && (state_r == ST_IDLE);
  assign div_last_s = (div_r == DIV_W'(CLK_DIV - 1));

  // Free-running sample timer, parked at zero while disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_r <= '0;
    end else if (!enable) begin
      timer_r <= '0;
    end else if (timer_r == TMR_W'(SAMPLE_PERIOD - 1)) begin
      timer_r <= '0;
    end else begin
      timer_r <= timer_r + TMR_W'(1);
    end
  end

  // Frame sequencer: chip select, SCLK generation, shifting and sample delivery.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r                <= ST_IDLE;
      div_r                  <= '0;
      bit_cnt_r              <= 5'd0;
      shreg_r                <= 16'h0000;
      adc_cs_n               <= 1'b1;
      adc_sclk               <= 1'b1;
      sample_if.sample_out   <= 12'h000;
      sample_if.sample_valid <= 1'b0;
      sample_if.frame_err    <= 1'b0;
    end else begin
      sample_if.sample_valid <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            state_r   <= ST_SETUP;
            adc_cs_n  <= 1'b0;
            div_r     <= '0;
            bit_cnt_r <= 5'd0;
          end
        end
        ST_SETUP: begin
          if (div_last_s) begin
            state_r  <= ST_SHIFT_LO;
            adc_sclk <= 1'b0;
            div_r    <= '0;
          end else begin
            div_r <= div_r + DIV_W'(1);
          end
        end
        ST_SHIFT_LO: begin
          // MISO is captured on the same edge that raises SCLK.
          if (div_last_s) begin
            state_r   <= ST_SHIFT_HI;
            adc_sclk  <= 1'b1;
            shreg_r   <= {shreg_r[14:0], adc_miso};
            bit_cnt_r <= bit_cnt_r + 5'd1;
            div_r     <= '0;
          end else begin
            div_r <= div_r + DIV_W'(1);
          end
        end
        ST_SHIFT_HI: begin
          if (div_last_s) begin
            div_r <= '0;
            if (bit_cnt_r < 5'd16) begin
              state_r  <= ST_SHIFT_LO;
              adc_sclk <= 1'b0;
            end else begin
              state_r                <= ST_DONE;
              adc_cs_n               <= 1'b1;
              adc_sclk               <= 1'b1;
              sample_if.sample_valid <= 1'b1;
              sample_if.sample_out   <= to_twos(shreg_r[11:0]);
              if (shreg_r[15:12] != 4'h0) begin
                sample_if.frame_err <= 1'b1;
              end
            end
          end else begin
            div_r <= div_r + DIV_W'(1);
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r  <= ST_IDLE;
          adc_cs_n <= 1'b1;
          adc_sclk <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_serial_reader.sv
// Directed bench for adc_serial_reader: two instances (CLK_DIV=2/period 100/offset binary,
// CLK_DIV=1/period 35/straight), each fed by a behavioural ADC that shifts on SCLK fall.
module tb_adc_serial_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic enable0 = 1'b0, enable1 = 1'b0;
  logic miso0 = 1'b0, miso1 = 1'b0;
  logic cs0, sclk0, cs1, sclk1;
  logic [15:0] code0 = 16'h0000, code1 = 16'h0000;
  int rises0 = 0, rises1 = 0, base0 = 0, base1 = 0;
  int cyc = 0;
  int total = 0, bad = 0;

  adc_serial_reader_if if0 ();
  adc_serial_reader_if if1 ();

  adc_serial_reader #(.CLK_DIV(2), .SAMPLE_PERIOD(100), .OFFSET_BINARY(1'b1)) dut0 (
    .clk(clk), .rst(rst), .enable(enable0), .adc_miso(miso0),
    .adc_cs_n(cs0), .adc_sclk(sclk0), .sample_if(if0)
  );

  adc_serial_reader #(.CLK_DIV(1), .SAMPLE_PERIOD(35), .OFFSET_BINARY(1'b0)) dut1 (
    .clk(clk), .rst(rst), .enable(enable1), .adc_miso(miso1),
    .adc_cs_n(cs1), .adc_sclk(sclk1), .sample_if(if1)
  );

  always @(posedge clk) cyc++;

  // ADC models: first bit on CS fall, later bits on SCLK falling edges.
  always @(posedge sclk0) if (cs0 === 1'b0) rises0++;
  always @(negedge cs0 or negedge sclk0) begin
    if (sclk0) begin
      base0 = rises0;
      miso0 = code0[15];
    end else if (rises0 - base0 < 16) begin
      miso0 = code0[15 - (rises0 - base0)];
    end
  end

  always @(posedge sclk1) if (cs1 === 1'b0) rises1++;
  always @(negedge cs1 or negedge sclk1) begin
    if (sclk1) begin
      base1 = rises1;
      miso1 = code1[15];
    end else if (rises1 - base1 < 16) begin
      miso1 = code1[15 - (rises1 - base1)];
    end
  end

  function automatic logic cur_cs(input bit sel);
    return sel ? cs1 : cs0;
  endfunction
  function automatic logic cur_valid(input bit sel);
    return sel ? if1.sample_valid : if0.sample_valid;
  endfunction
  function automatic logic [11:0] cur_samp(input bit sel);
    return sel ? if1.sample_out : if0.sample_out;
  endfunction
  function automatic int cur_rises(input bit sel);
    return sel ? (rises1 - base1) : (rises0 - base0);
  endfunction

  // Waits (bounded) for the next CS fall, then follows the frame to its strobe.
  // Timeouts leave t_cs / t_valid at -1 so the caller's latency checks fail.
  task automatic capture(input bit sel, input int drop_at,
                         output int t_cs, output int t_valid, output int cs_low,
                         output int nrise, output logic [11:0] samp);
    int n;
    t_cs = -1; t_valid = -1; cs_low = 0; nrise = 0; samp = 12'h000;
    n = 0;
    while (n < 300 && cur_cs(sel) !== 1'b0) begin
      @(negedge clk);
      n++;
    end
    if (cur_cs(sel) !== 1'b0) return;
    t_cs = cyc;
    n = 0;
    while (n < 300) begin
      if (drop_at != 0 && n == drop_at) enable0 = 1'b0;
      if (cur_valid(sel) === 1'b1) begin
        t_valid = cyc;
        samp    = cur_samp(sel);
        nrise   = cur_rises(sel);
        break;
      end
      if (cur_cs(sel) === 1'b0) cs_low++;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; enable0 = 1'b0; enable1 = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (cs0 !== 1'b1) begin bad++; $display("FAIL reset_cs_n: got %b want 1", cs0); end
    total++; if (sclk0 !== 1'b1) begin bad++; $display("FAIL reset_sclk: got %b want 1", sclk0); end
    total++; if (if0.sample_out !== 12'h000) begin bad++; $display("FAIL reset_sample_out: got %h want 000", if0.sample_out); end
    total++; if (if0.sample_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", if0.sample_valid); end
    total++; if (if0.frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err: got %b want 0", if0.frame_err); end
    total++; if (cs1 !== 1'b1) begin bad++; $display("FAIL reset_cs_n_b: got %b want 1", cs1); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (cs0 !== 1'b1) begin bad++; $display("FAIL idle_disabled_cs_n: got %b want 1", cs0); end
  endtask

  task automatic test_basic();
    int t_cs, t_v, lo, nr, prev;
    logic [11:0] s;
    code0 = 16'h0ABC; enable0 = 1'b1;
    capture(1'b0, 0, t_cs, t_v, lo, nr, s);
    total++; if (t_v - t_cs !== 66) begin bad++; $display("FAIL basic_latency: got %0d want 66", t_v - t_cs); end
    total++; if (lo !== 66) begin bad++; $display("FAIL basic_cs_low: got %0d want 66", lo); end
    total++; if (nr !== 16) begin bad++; $display("FAIL basic_sclk_rises: got %0d want 16", nr); end
    total++; if (s !== 12'h2BC) begin bad++; $display("FAIL basic_sample: got %h want 2bc", s); end
    @(negedge clk);
    total++; if (if0.sample_valid !== 1'b0) begin bad++; $display("FAIL basic_strobe_width: got %b want 0", if0.sample_valid); end
    total++; if (if0.sample_out !== 12'h2BC) begin bad++; $display("FAIL basic_hold: got %h want 2bc", if0.sample_out); end
    prev = t_cs;
    capture(1'b0, 0, t_cs, t_v, lo, nr, s);
    total++; if (t_cs - prev !== 100) begin bad++; $display("FAIL basic_period: got %0d want 100", t_cs - prev); end
    total++; if (s !== 12'h2BC) begin bad++; $display("FAIL basic_sample2: got %h want 2bc", s); end
  endtask

  task automatic test_codes();
    logic [15:0] codes [3];
    logic [11:0] exps [3];
    int t_cs, t_v, lo, nr;
    logic [11:0] s;
    codes = '{16'h0000, 16'h0800, 16'h0FFF};
    exps  = '{12'h800, 12'h000, 12'h7FF};
    for (int i = 0; i < 3; i++) begin
      code0 = codes[i];
      capture(1'b0, 0, t_cs, t_v, lo, nr, s);
      total++; if (s !== exps[i]) begin bad++; $display("FAIL codes_sample[%0d]: got %h want %h", i, s, exps[i]); end
      total++; if (if0.frame_err !== 1'b0) begin bad++; $display("FAIL codes_frame_err[%0d]: got %b want 0", i, if0.frame_err); end
      @(negedge clk);
      total++; if (if0.sample_valid !== 1'b0) begin bad++; $display("FAIL codes_one_strobe[%0d]: got %b want 0", i, if0.sample_valid); end
    end
  endtask

  task automatic test_frame_err();
    int t_cs, t_v, lo, nr;
    logic [11:0] s;
    code0 = 16'hF123;
    capture(1'b0, 0, t_cs, t_v, lo, nr, s);
    total++; if (s !== 12'h923) begin bad++; $display("FAIL err_sample: got %h want 923", s); end
    total++; if (if0.frame_err !== 1'b1) begin bad++; $display("FAIL err_set: got %b want 1", if0.frame_err); end
    code0 = 16'h0ABC;
    capture(1'b0, 0, t_cs, t_v, lo, nr, s);
    total++; if (s !== 12'h2BC) begin bad++; $display("FAIL err_clean_sample: got %h want 2bc", s); end
    total++; if (if0.frame_err !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b want 1", if0.frame_err); end
    rst = 1'b1;
    @(negedge clk);
    total++; if (if0.frame_err !== 1'b0) begin bad++; $display("FAIL err_cleared: got %b want 0", if0.frame_err); end
    rst = 1'b0;
    @(negedge clk);
    total++; if (cs0 !== 1'b0) begin bad++; $display("FAIL first_frame_after_rst: got %b want 0", cs0); end
  endtask

  task automatic test_mid_reset();
    int n, t_rel, t_cs, t_v, lo, nr;
    logic [11:0] s;
    n = 0;
    while (n < 200 && !(cs0 === 1'b0 && (rises0 - base0) == 8)) begin
      @(negedge clk);
      n++;
    end
    total++; if (rises0 - base0 !== 8) begin bad++; $display("FAIL midrst_reach8: got %0d want 8", rises0 - base0); end
    rst = 1'b1;
    @(negedge clk);
    total++; if (cs0 !== 1'b1) begin bad++; $display("FAIL midrst_cs_n: got %b want 1", cs0); end
    total++; if (sclk0 !== 1'b1) begin bad++; $display("FAIL midrst_sclk: got %b want 1", sclk0); end
    total++; if (if0.sample_out !== 12'h000) begin bad++; $display("FAIL midrst_sample_out: got %h want 000", if0.sample_out); end
    total++; if (if0.sample_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %b want 0", if0.sample_valid); end
    rst = 1'b0; code0 = 16'h0456; t_rel = cyc;
    capture(1'b0, 0, t_cs, t_v, lo, nr, s);
    total++; if (t_cs - t_rel !== 1) begin bad++; $display("FAIL midrst_restart: got %0d want 1", t_cs - t_rel); end
    total++; if (t_v - t_cs !== 66) begin bad++; $display("FAIL midrst_latency: got %0d want 66", t_v - t_cs); end
    total++; if (s !== 12'hC56) begin bad++; $display("FAIL midrst_sample: got %h want c56", s); end
  endtask

  task automatic test_enable_drop();
    int t_cs, t_v, lo, nr, lows, strobes;
    logic [11:0] s;
    code0 = 16'h0ABC;
    capture(1'b0, 29, t_cs, t_v, lo, nr, s);
    total++; if (t_v - t_cs !== 66) begin bad++; $display("FAIL drop_latency: got %0d want 66", t_v - t_cs); end
    total++; if (s !== 12'h2BC) begin bad++; $display("FAIL drop_sample: got %h want 2bc", s); end
    lows = 0; strobes = 0;
    repeat (150) begin
      @(negedge clk);
      if (cs0 !== 1'b1) lows++;
      if (if0.sample_valid !== 1'b0) strobes++;
    end
    total++; if (lows !== 0) begin bad++; $display("FAIL drop_no_cs: got %0d want 0", lows); end
    total++; if (strobes !== 0) begin bad++; $display("FAIL drop_no_strobe: got %0d want 0", strobes); end
    enable0 = 1'b1;
    @(negedge clk);
    total++; if (cs0 !== 1'b0) begin bad++; $display("FAIL reenable_cs_n: got %b want 0", cs0); end
    enable0 = 1'b0;
  endtask

  task automatic test_back_to_back();
    int t_cs, t_v, lo, nr, prev_cs, prev_v;
    logic [11:0] s;
    code1 = 16'h0ABC; enable1 = 1'b1;
    capture(1'b1, 0, t_cs, t_v, lo, nr, s);
    total++; if (t_v - t_cs !== 33) begin bad++; $display("FAIL b2b_latency: got %0d want 33", t_v - t_cs); end
    total++; if (lo !== 33) begin bad++; $display("FAIL b2b_cs_low: got %0d want 33", lo); end
    total++; if (nr !== 16) begin bad++; $display("FAIL b2b_sclk_rises: got %0d want 16", nr); end
    total++; if (s !== 12'hABC) begin bad++; $display("FAIL b2b_sample: got %h want abc", s); end
    prev_cs = t_cs; prev_v = t_v;
    capture(1'b1, 0, t_cs, t_v, lo, nr, s);
    total++; if (t_cs - prev_cs !== 35) begin bad++; $display("FAIL b2b_period: got %0d want 35", t_cs - prev_cs); end
    total++; if (t_cs - prev_v !== 2) begin bad++; $display("FAIL b2b_gap: got %0d want 2", t_cs - prev_v); end
    total++; if (s !== 12'hABC) begin bad++; $display("FAIL b2b_sample2: got %h want abc", s); end
    enable1 = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_codes();
    test_frame_err();
    test_mid_reset();
    test_enable_drop();
    test_back_to_back();
    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
